// File: rtl/data_memory_lsu_if.sv
// Request/response bus of the data memory load/store unit.
// A request moves on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse that qualifies rsp_rdata/rsp_err.
interface data_memory_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-lane data memory with load/store front end: byte/half/word accesses,
// sign/zero-extended loads, word-crossing accesses split into two beats.
module data_memory_lsu #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int IDX_W        = $clog2(DEPTH_WORDS),
    parameter bit ERR_ON_RANGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    data_memory_lsu_if.slave  bus,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT2 = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic             r_we;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [1:0]       r_off;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_be2;
    logic [31:0]      r_wd_hi;
    logic             r_err;
    logic [31:0]      r_hold;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi;

    logic             w_ready;
    logic             w_rsp_valid;
    logic             w_acc;
    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idx2;
    logic [7:0]       w_base;
    logic [7:0]       w_m8;
    logic             w_cross;
    logic             w_hi_nz;
    logic             w_err;
    logic [63:0]      w_wsh;
    logic [3:0]       w_be;
    logic [IDX_W-1:0] w_widx;
    logic [31:0]      w_wdat;
    logic [31:0]      w_rsh;
    logic [31:0]      w_asm;

    // Request decode: an 8-lane mask spanning two words; the upper nibble is the second beat.
    assign w_acc   = bus.req_valid & w_ready;
    assign w_off   = bus.req_addr[1:0];
    assign w_idx   = bus.req_addr[IDX_W+1:2];
    assign w_idx2  = r_idx + IDX_W'(1);

    always_comb begin
        case (bus.req_size)
            2'b00:   w_base = 8'h01;
            2'b01:   w_base = 8'h03;
            default: w_base = 8'h0F;
        endcase
    end

    assign w_m8    = w_base << w_off;
    assign w_cross = |w_m8[7:4];
    assign w_hi_nz = (bus.req_addr >> (IDX_W + 2)) != 32'd0;
    assign w_err   = ERR_ON_RANGE & (w_hi_nz | (w_cross & (&w_idx)));
    assign w_wsh   = {32'd0, bus.req_wdata} << {w_off, 3'b000};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; erroring crossing accesses still spend the BEAT2 cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_next = w_cross ? S_BEAT2 : S_RESP;
            S_BEAT2: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_ready       = (r_state == S_IDLE);
        w_rsp_valid   = (r_state == S_RESP);
        bus.req_ready = w_ready;
        bus.rsp_valid = w_rsp_valid;
        bus.rsp_rdata = w_rsp_valid ? w_asm : r_hold;
        bus.rsp_err   = w_rsp_valid & r_err;
        o_dbg_state   = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_off   <= 2'b00;
            r_idx   <= '0;
            r_be2   <= 4'h0;
            r_wd_hi <= 32'd0;
            r_err   <= 1'b0;
            r_hold  <= 32'd0;
        end else begin
            if (w_acc) begin
                r_we    <= bus.req_we;
                r_size  <= bus.req_size;
                r_uns   <= bus.req_unsigned;
                r_off   <= w_off;
                r_idx   <= w_idx;
                r_be2   <= (bus.req_we && !w_err) ? w_m8[7:4] : 4'h0;
                r_wd_hi <= w_wsh[63:32];
                r_err   <= w_err;
            end
            if (w_rsp_valid) r_hold <= w_asm;
        end
    end

    // Single write port: beat 1 at acceptance, beat 2 in BEAT2 on the next word
    always_comb begin
        w_be   = 4'h0;
        w_widx = w_idx;
        w_wdat = w_wsh[31:0];
        if (w_acc && bus.req_we && !w_err) begin
            w_be = w_m8[3:0];
        end else if (r_state == S_BEAT2) begin
            w_be   = r_be2;
            w_widx = w_idx2;
            w_wdat = r_wd_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc)              r_lo <= r_mem[w_idx];
        if (r_state == S_BEAT2) r_hi <= r_mem[w_idx2];
        for (int l = 0; l < 4; l++) begin
            if (w_be[l]) r_mem[w_widx][8*l +: 8] <= w_wdat[8*l +: 8];
        end
    end

    // Load assembly; stale r_hi bytes of non-crossing loads are masked by the size select
    assign w_rsh = 32'({r_hi, r_lo} >> {r_off, 3'b000});

    always_comb begin
        w_asm = 32'd0;
        if (!r_we && !r_err) begin
            case (r_size)
                2'b00:   w_asm = r_uns ? {24'd0, w_rsh[7:0]}  : {{24{w_rsh[7]}},  w_rsh[7:0]};
                2'b01:   w_asm = r_uns ? {16'd0, w_rsh[15:0]} : {{16{w_rsh[15]}}, w_rsh[15:0]};
                default: w_asm = w_rsh;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: directed plan steps plus random
// loads/stores compared with a byte-addressed reference memory.
module tb_data_memory_lsu;
    localparam int DEPTH = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] ref_mem [0:4*DEPTH-1];

    always #5 clk = ~clk;

    data_memory_lsu_if bus ();

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .ERR_ON_RANGE(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte array, range by plain address arithmetic, extension by value
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] er, output logic ee, output int el);
        int n;
        logic [63:0] a;
        logic [31:0] v;
        n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        el = (int'(addr[1:0]) + n > 4) ? 2 : 1;
        a  = {32'd0, addr};
        ee = (a + 64'(n)) > 64'(4 * DEPTH);
        er = 32'd0;
        if (!ee) begin
            if (we) begin
                for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(addr) + k];
                if (size == 2'd0 && !uns && v[7])  v = v | 32'hFFFF_FF00;
                if (size == 2'd1 && !uns && v[15]) v = v | 32'hFFFF_0000;
                er = v;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] got);
        logic [31:0] er;
        logic        ee;
        int          el;
        int          lat;
        int          k;
        logic        gerr;
        model(we, size, uns, addr, wdata, er, ee, el);
        @(negedge clk);
        k = 0;
        while (!bus.req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom();
        bus.req_wdata    = $urandom();
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got  = bus.rsp_rdata;
        gerr = bus.rsp_err;
        check({tag, ".lat"}, 32'(lat), 32'(el));
        check({tag, ".rdata"}, got, er);
        check({tag, ".err"}, 32'(gerr), 32'(ee));
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".hold"}, bus.rsp_rdata, er);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] wd;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;

        // Reset state
        #22;
        check("rst.ready", 32'(bus.req_ready), 32'd1);
        check("rst.valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rdata", bus.rsp_rdata, 32'd0);
        check("rst.err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known contents for the random window
        for (int i = 0; i < 32; i++) run_op("fill", 1'b1, 2'd2, 1'b0, 32'h200 + 32'(4 * i), $urandom(), got);

        // Reset during BEAT2 of a crossing store: beat 1 stays written, beat 2 never happens
        wd = 32'h5566_7788;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h202; bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("b2.ready", 32'(bus.req_ready), 32'd0);
        check("b2.valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst.ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst.valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst.rdata", bus.rsp_rdata, 32'd0);
        ref_mem[32'h202] = wd[7:0];
        ref_mem[32'h203] = wd[15:8];
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst.w200", 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, got);
        run_op("post_rst.w204", 1'b0, 2'd2, 1'b0, 32'h204, 32'd0, got);

        // Word / byte store and loads
        run_op("st.w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, got);
        run_op("ld.w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, got);
        check("lit.w10", got, 32'hDEAD_BEEF);
        run_op("st.b11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0080, got);
        run_op("ld.b11s", 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, got);
        check("lit.b11s", got, 32'hFFFF_FF80);
        run_op("ld.b11u", 1'b0, 2'd0, 1'b1, 32'h11, 32'd0, got);
        check("lit.b11u", got, 32'h0000_0080);
        run_op("ld.w10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, got);
        check("lit.w10b", got, 32'hDEAD_80EF);

        // Crossing halfword
        run_op("st.h23", 1'b1, 2'd1, 1'b0, 32'h23, 32'h0000_A1B2, got);
        run_op("ld.b23", 1'b0, 2'd0, 1'b1, 32'h23, 32'd0, got);
        check("lit.b23", got, 32'h0000_00B2);
        run_op("ld.b24", 1'b0, 2'd0, 1'b1, 32'h24, 32'd0, got);
        check("lit.b24", got, 32'h0000_00A1);
        run_op("ld.h23u", 1'b0, 2'd1, 1'b1, 32'h23, 32'd0, got);
        check("lit.h23u", got, 32'h0000_A1B2);
        run_op("ld.h23s", 1'b0, 2'd1, 1'b0, 32'h23, 32'd0, got);

        // Crossing word
        run_op("st.w2e", 1'b1, 2'd2, 1'b0, 32'h2E, 32'h1122_3344, got);
        for (int i = 0; i < 4; i++) run_op("ld.b2e", 1'b0, 2'd0, 1'b1, 32'h2E + 32'(i), 32'd0, got);
        run_op("ld.w2e", 1'b0, 2'd2, 1'b0, 32'h2E, 32'd0, got);
        check("lit.w2e", got, 32'h1122_3344);

        // Range errors: nothing written, nothing wraps
        run_op("st.w0", 1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, got);
        run_op("st.wffc", 1'b1, 2'd2, 1'b0, 32'hFFC, 32'h0BAD_CAB5, got);
        run_op("st.w1000", 1'b1, 2'd2, 1'b0, 32'h1000, 32'h1234_5678, got);
        run_op("st.wffe", 1'b1, 2'd2, 1'b0, 32'hFFE, 32'h8765_4321, got);
        run_op("ld.wffe", 1'b0, 2'd2, 1'b0, 32'hFFE, 32'd0, got);
        run_op("ld.hfff", 1'b0, 2'd1, 1'b0, 32'hFFF, 32'd0, got);
        run_op("ld.bfff", 1'b0, 2'd0, 1'b1, 32'hFFF, 32'd0, got);
        run_op("ld.w0", 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, got);
        check("lit.w0", got, 32'hCAFE_F00D);
        run_op("ld.wffc", 1'b0, 2'd2, 1'b0, 32'hFFC, 32'd0, got);
        check("lit.wffc", got, 32'h0BAD_CAB5);
        run_op("ld.hi", 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'd0, got);

        // Random traffic inside the prefilled window
        for (int i = 0; i < 200; i++) begin
            run_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'h200 + 32'($urandom_range(0, 123)), $urandom(), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        n_mis++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "timeout");
    end

endmodule
